// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer: captures an 8-bit word, scans it through an external
// 8:1 mux (mux_a / mux_s -> mux_out) and streams the selected bits out on a
// valid/ready serial interface. LSB_FIRST selects the scan order.
// Optional feature: define MUX_SCAN_PARITY_EN to append an even-parity bit
// after the 8 data bits (frame length 9, ser_last on the parity bit).
module mux_scan_serializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic [7:0] mux_a,
  output logic [2:0] mux_s,
  input  logic       mux_out,
  output logic       ser_data,
  output logic       ser_valid,
  output logic       ser_last,
  input  logic       ser_ready,
  output logic       busy
);

  // Scan index of the first and of the eighth bit of a frame.
  localparam logic [2:0] FIRST_IDX = LSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [2:0] LAST_IDX  = LSB_FIRST ? 3'd7 : 3'd0;

`ifdef MUX_SCAN_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t     state, state_nxt;
  logic [7:0] mux_a_nxt;
  logic [2:0] mux_s_nxt;
  logic       at_last;

`ifdef MUX_SCAN_PARITY_EN
  logic par_acc, par_nxt;
`endif

  // The eighth bit sits at the far end of the scan; the index never wraps.
  assign at_last = (mux_s == LAST_IDX);

  // State, captured word and scan index registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; the datapath registers are reset too because mux_a and
  // mux_s are visible outputs with defined reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mux_a <= 8'h00;
      mux_s <= 3'd0;
    end else begin
      state <= state_nxt;
      mux_a <= mux_a_nxt;
      mux_s <= mux_s_nxt;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  // Parity accumulator: XOR of the bits transferred so far in this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
    end else begin
      par_acc <= par_nxt;
    end
  end
`endif

  // Next-state logic and handshake outputs; ser_valid depends on state only.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt  = state;
    mux_a_nxt  = mux_a;
    mux_s_nxt  = mux_s;
    load_ready = 1'b0;
    busy       = 1'b1;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    ser_last   = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    par_nxt    = par_acc;
`endif

    case (state)
      IDLE: begin
        load_ready = 1'b1;
        busy       = 1'b0;
        if (load_valid) begin
          mux_a_nxt = load_data;
          mux_s_nxt = FIRST_IDX;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = mux_out;
`ifndef MUX_SCAN_PARITY_EN
        ser_last  = at_last;
`endif
        if (ser_ready) begin
`ifdef MUX_SCAN_PARITY_EN
          par_nxt = par_acc ^ mux_out;
`endif
          if (at_last) begin
`ifdef MUX_SCAN_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = IDLE;
`endif
          end else if (LSB_FIRST) begin
            mux_s_nxt = mux_s + 3'd1;
          end else begin
            mux_s_nxt = mux_s - 3'd1;
          end
        end
      end

`ifdef MUX_SCAN_PARITY_EN
      PAR: begin
        ser_valid = 1'b1;
        ser_data  = par_acc;
        ser_last  = 1'b1;
        if (ser_ready) begin
          par_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
`endif

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb_mux_scan_serializer: runs one LSB-first and one MSB-first instance on the
// same stimulus, compares both against a frame-level model on every falling
// edge, and pins the model with hand-computed serial streams.
`timescale 1ns/1ps
module tb_mux_scan_serializer;

`ifdef MUX_SCAN_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       ser_ready = 1'b1;

  logic       load_ready [2];
  logic [7:0] mux_a      [2];
  logic [2:0] mux_s      [2];
  logic       mux_out    [2];
  logic       ser_data   [2];
  logic       ser_valid  [2];
  logic       ser_last   [2];
  logic       busy       [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // External 8:1 muxes.
  assign mux_out[0] = mux_a[0][mux_s[0]];
  assign mux_out[1] = mux_a[1][mux_s[1]];

  mux_scan_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready[0]), .mux_a(mux_a[0]), .mux_s(mux_s[0]),
    .mux_out(mux_out[0]), .ser_data(ser_data[0]), .ser_valid(ser_valid[0]),
    .ser_last(ser_last[0]), .ser_ready(ser_ready), .busy(busy[0])
  );

  mux_scan_serializer #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready[1]), .mux_a(mux_a[1]), .mux_s(mux_s[1]),
    .mux_out(mux_out[1]), .ser_data(ser_data[1]), .ser_valid(ser_valid[1]),
    .ser_last(ser_last[1]), .ser_ready(ser_ready), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Frame-level model: per instance, whether a frame is open, its word, and
  // how many bits have been transferred so far.
  logic       m_busy [2];
  logic [7:0] m_word [2];
  int         m_k    [2];
  logic [2:0] m_hold [2];

  function automatic logic [2:0] scan_idx(input int d, input int k);
    logic [2:0] kk;
    kk = 3'(k);
    return (d == 0) ? kk : 3'd7 - kk;
  endfunction

  // Model update on the same edges the design reacts to.
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_busy[d] = 1'b0; m_word[d] = 8'h00; m_k[d] = 0; m_hold[d] = 3'd0;
      end else if (!m_busy[d]) begin
        if (load_valid) begin
          m_busy[d] = 1'b1; m_word[d] = load_data; m_k[d] = 0;
        end
      end else if (ser_ready) begin
        m_k[d] = m_k[d] + 1;
        if (m_k[d] == FRAME_LEN) begin
          m_busy[d] = 1'b0;
          m_hold[d] = scan_idx(d, 7);
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [2:0] es;
      logic       ed;
      es = !m_busy[d] ? m_hold[d] : scan_idx(d, (m_k[d] < 8) ? m_k[d] : 7);
      ed = !m_busy[d] ? 1'b0 : (m_k[d] < 8) ? m_word[d][scan_idx(d, m_k[d])] : ^m_word[d];
      check($sformatf("dut%0d ser_valid", d), ser_valid[d], m_busy[d]);
      check($sformatf("dut%0d ser_data", d), ser_data[d], ed);
      check($sformatf("dut%0d ser_last", d), ser_last[d], m_busy[d] && (m_k[d] == FRAME_LEN - 1));
      check($sformatf("dut%0d mux_s", d), mux_s[d], es);
      check($sformatf("dut%0d mux_a", d), mux_a[d], m_word[d]);
      check($sformatf("dut%0d load_ready", d), load_ready[d], !m_busy[d]);
      check($sformatf("dut%0d busy", d), busy[d], m_busy[d]);
    end
  end

  // Collector of transferred bits; cleared whenever the instance is idle.
  logic [15:0] col_bits [2];
  logic [15:0] col_last [2];
  int          col_n    [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n || !busy[d]) begin
        col_bits[d] = 16'h0; col_last[d] = 16'h0; col_n[d] = 0;
      end else if (ser_valid[d] && ser_ready) begin
        col_bits[d] = {col_bits[d][14:0], ser_data[d]};
        col_last[d] = {col_last[d][14:0], ser_last[d]};
        col_n[d]    = col_n[d] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
  endtask

  // Let the current frame run to completion with a bounded wait.
  task automatic run_frame(input string name);
    for (int i = 0; i < 60; i++) begin
      if (col_n[0] >= FRAME_LEN && col_n[1] >= FRAME_LEN) break;
      tick();
    end
    check({name, " bit count lsb"}, col_n[0], FRAME_LEN);
    check({name, " bit count msb"}, col_n[1], FRAME_LEN);
  endtask

  // seq: transferred data bits, first bit in the MSB; par: expected parity.
  task automatic check_stream(input string name, input int d, input logic [7:0] seq, input logic par);
    logic [15:0] exp;
`ifdef MUX_SCAN_PARITY_EN
    exp = {7'd0, seq, par};
`else
    exp = {8'd0, seq};
    if (par) exp = exp;
`endif
    check($sformatf("%s stream dut%0d", name, d), col_bits[d], exp);
    check($sformatf("%s last dut%0d", name, d), col_last[d], 16'h0001);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset load_ready", load_ready[0], 1'b1);
    check("reset ser_valid", ser_valid[0], 1'b0);
    check("reset mux_a", mux_a[0], 8'h00);
    check("reset mux_s", mux_s[1], 3'd0);
    rst_n = 1'b1;

    // A5 accepted on the first edge after release, ser_ready held high.
    accept(8'hA5);
    check("latency ser_valid", ser_valid[0], 1'b1);
    check("first mux_s lsb", mux_s[0], 3'd0);
    check("first mux_s msb", mux_s[1], 3'd7);
    run_frame("A5");
    check_stream("A5", 0, 8'hA5, 1'b0);
    check_stream("A5", 1, 8'hA5, 1'b0);
    check("A5 end mux_s lsb", mux_s[0], 3'd7);
    check("A5 load_ready after", load_ready[0], 1'b1);

    // 81: MSB-first scans 7..0.
    accept(8'h81);
    run_frame("81");
    check_stream("81", 1, 8'h81, 1'b0);
    check("81 end mux_s msb", mux_s[1], 3'd0);

    // 3C with a 5-cycle stall after two transfers.
    accept(8'h3C);
    tick();
    tick();
    ser_ready = 1'b0;
    repeat (5) tick();
    check("stall mux_s lsb", mux_s[0], 3'd2);
    check("stall mux_s msb", mux_s[1], 3'd5);
    check("stall ser_valid", ser_valid[0], 1'b1);
    check("stall bits so far", col_n[0], 2);
    ser_ready = 1'b1;
    run_frame("3C");
    check_stream("3C", 0, 8'h3C, 1'b0);
    check_stream("3C", 1, 8'h3C, 1'b0);

    // FF offered throughout an 0F frame, taken in the IDLE cycle after it.
    accept(8'h0F);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    check("busy load_ready", load_ready[0], 1'b0);
    run_frame("0F");
    check_stream("0F", 0, 8'hF0, 1'b0);
    check_stream("0F", 1, 8'h0F, 1'b0);
    check("0F mux_a held", mux_a[0], 8'h0F);
    tick();
    load_valid = 1'b0;
    check("FF accepted", mux_a[0], 8'hFF);
    run_frame("FF");
    check_stream("FF", 0, 8'hFF, 1'b0);

    // Reset after three transfers of C3.
    accept(8'hC3);
    repeat (3) tick();
    check("pre-reset mux_s", mux_s[0], 3'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async ser_valid", ser_valid[0], 1'b0);
    check("async mux_s lsb", mux_s[0], 3'd0);
    check("async mux_s msb", mux_s[1], 3'd0);
    check("async busy", busy[1], 1'b0);
    tick();
    rst_n = 1'b1;
    accept(8'h01);
    run_frame("01");
    check_stream("01", 0, 8'h80, 1'b1);
    check_stream("01", 1, 8'h01, 1'b1);

`ifdef MUX_SCAN_PARITY_EN
    tick();
    accept(8'h07);
    run_frame("07");
    check_stream("07", 0, 8'hE0, 1'b1);
    tick();
    accept(8'h03);
    run_frame("03");
    check_stream("03", 0, 8'hC0, 1'b0);
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
